// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encoding (common with the
// transmitter), default link parameters and small timing helpers.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned BPS_MAX_DEFAULT = 5208;
  localparam int unsigned BIT_MAX_DEFAULT = 8;

  function automatic int unsigned half_bit_last(input int unsigned bps_max);
    return bps_max / 2 - 1;
  endfunction

  function automatic int unsigned full_bit_last(input int unsigned bps_max);
    return bps_max - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not see a false edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, finds the start bit, samples data bits at
// mid-bit, checks the stop bit and strobes either a valid byte or a framing error.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned BPS_MAX = BPS_MAX_DEFAULT,
  parameter int unsigned BIT_MAX = BIT_MAX_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_frame_err,
  output logic               rx_busy
);

  localparam int unsigned CW = $clog2(BPS_MAX);
  localparam int unsigned BW = $clog2(BIT_MAX + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit_last(BPS_MAX));
  localparam logic [CW-1:0] FULL_LAST = CW'(full_bit_last(BPS_MAX));
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_MAX - 1);

  uart_state_t       state;
  uart_state_t       state_nxt;
  logic              s2;
  logic              s3;
  logic [1:0]        fill;
  logic              armed;
  logic              fall;
  logic [CW-1:0]     bps_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [BIT_MAX-1:0] shift_reg;
  logic [BIT_MAX-1:0] shift_nxt;
  logic              half_hit;
  logic              full_hit;
  logic              last_bit;
  logic              start_tick;
  logic              data_tick;
  logic              stop_tick;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (s2)
  );

  // The synchroniser is preloaded high, so edges are only trusted once s2 has
  // carried a real high sample from the line; a line low at release is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s3    <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s3    <= s2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & s2);
    end
  end

  assign fall     = armed & s3 & ~s2;
  assign half_hit = (bps_cnt == HALF_LAST);
  assign full_hit = (bps_cnt == FULL_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (fall) state_nxt = START;
      START:   if (half_hit) state_nxt = s2 ? IDLE : DATA;
      DATA:    if (full_hit && last_bit) state_nxt = STOP;
      STOP:    if (full_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy    = (state != IDLE);
    start_tick = (state == START) && half_hit;
    data_tick  = (state == DATA) && full_hit;
    stop_tick  = (state == STOP) && full_hit;
  end

  // LSB arrives first, so each new bit enters at the top and walks down to bit 0.
  always_comb begin
    shift_nxt              = shift_reg >> 1;
    shift_nxt[BIT_MAX-1]   = s2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bps_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          bps_cnt <= '0;
          bit_cnt <= '0;
        end
        START: begin
          bps_cnt <= start_tick ? '0 : bps_cnt + 1'b1;
        end
        DATA: begin
          if (data_tick) begin
            bps_cnt   <= '0;
            shift_reg <= shift_nxt;
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
          end else begin
            bps_cnt <= bps_cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_tick) begin
            bps_cnt <= '0;
            if (s2) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            bps_cnt <= bps_cnt + 1'b1;
          end
        end
        default: begin
          bps_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: drives serial frames bit by bit and
// compares strobes, data and strobe timing against a frame-level reference model.
module tb_uart_rx;

  localparam int BPS = 16;
  localparam int NB  = 8;
  // Line fall to strobe: 3 clocks to START, then half a bit plus nine full bits.
  localparam int STROBE_LAT = 3 + BPS / 2 + (NB + 1) * BPS;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int         cyc;
  int         compared;
  int         mismatched;
  int         both_high;
  logic [7:0] model_data;
  ev_t        obs_q[$];
  ev_t        exp_q[$];

  uart_rx #(
    .BPS_MAX(BPS),
    .BIT_MAX(NB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) obs_q.push_back('{err: 1'b0, data: rx_data, cyc: cyc});
    if (rx_frame_err) obs_q.push_back('{err: 1'b1, data: 8'h00, cyc: cyc});
    if (rx_valid && rx_frame_err) both_high++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One UART frame, start bit driven immediately, followed by gap idle-high cycles.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_good, input int gap);
    logic [9:0] bits;
    int c0;
    bits = {stop_good, data, 1'b0};
    c0   = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      wait_cycles(BPS / 2);
      checkOutput($sformatf("busy_bit%0d", i), rx_busy, 1);
      wait_cycles(BPS / 2);
    end
    rx = 1'b1;
    if (stop_good) begin
      exp_q.push_back('{err: 1'b0, data: data, cyc: c0 + STROBE_LAT});
      model_data = data;
    end else begin
      exp_q.push_back('{err: 1'b1, data: 8'h00, cyc: c0 + STROBE_LAT});
    end
    wait_cycles(gap);
  endtask

  task automatic check_events(input string tag);
    int n;
    checkOutput({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_kind"}, obs_q[i].err, exp_q[i].err);
      checkOutput({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      if (!exp_q[i].err) checkOutput({tag, "_data"}, obs_q[i].data, exp_q[i].data);
    end
    checkOutput({tag, "_rx_data"}, rx_data, model_data);
    checkOutput({tag, "_idle"}, rx_busy, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_data"}, rx_data, 0);
    checkOutput({tag, "_valid"}, rx_valid, 0);
    checkOutput({tag, "_err"}, rx_frame_err, 0);
    checkOutput({tag, "_busy"}, rx_busy, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit good;
    int gap;
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    both_high  = 0;
    model_data = 8'h00;
    rst        = 1'b0;
    rx         = 1'b1;
    wait_cycles(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    wait_cycles(10);

    applyStimulus(8'h55, 1'b1, 10);
    check_events("single_55");

    applyStimulus(8'hA3, 1'b1, 0);
    applyStimulus(8'h0F, 1'b1, 10);
    if (obs_q.size() >= 2) checkOutput("b2b_spacing", obs_q[1].cyc - obs_q[0].cyc, 10 * BPS);
    check_events("b2b");

    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_cycles(30);
    check_events("glitch");

    applyStimulus(8'hC4, 1'b0, 10);
    check_events("bad_stop");

    rx = 1'b0;
    wait_cycles(BPS);
    for (int i = 0; i < 3; i++) begin
      rx = (8'h5A >> i) & 1'b1;
      wait_cycles(BPS);
    end
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2);
    check_reset_outputs("mid_reset");
    model_data = 8'h00;
    rx  = 1'b1;
    rst = 1'b1;
    wait_cycles(10);
    check_events("aborted");
    applyStimulus(8'h81, 1'b1, 10);
    check_events("after_reset");

    rst = 1'b0;
    rx  = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    model_data = 8'h00;
    wait_cycles(40);
    checkOutput("low_release_busy", rx_busy, 0);
    rx = 1'b1;
    wait_cycles(10);
    check_events("low_release");
    applyStimulus(8'h3C, 1'b1, 10);
    check_events("low_release_frame");

    for (int f = 0; f < 24; f++) begin
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 99) < 80);
      gap  = good ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12));
      applyStimulus(d, good, gap);
      check_events($sformatf("rand%0d", f));
    end

    checkOutput("strobe_overlap", both_high, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
